// File: rtl/dc_block_ctrl.sv
// Sequencer for the receive-path DC blocker: arms it, discards its start-up transient,
// freezes it on request with a hold-off before resuming, and gates its output downstream.
module dc_block_ctrl #(
    parameter int DATA_W         = 13,
    parameter int SETTLE_SAMPLES = 512,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              freeze_i,
    input  logic              adc_valid_i,
    output logic              blk_en_o,
    output logic              blk_valid_o,
    input  logic              blk_valid_i,
    input  logic [DATA_W-1:0] blk_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        state_o,
    output logic              settled_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int SW = $clog2(SETTLE_SAMPLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        FREEZE = 2'd3
    } state_t;

    state_t          state;
    state_t          ret_state;
    logic [SW-1:0]   settle_cnt;
    logic [HW-1:0]   hold_cnt;

    assign state_o = state;

    // NOTE: every register here, counters included, is reset synchronously so the
    // block comes out of reset in a fully defined state; all updates are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            settle_cnt  <= '0;
            hold_cnt    <= '0;
            blk_en_o    <= 1'b0;
            blk_valid_o <= 1'b0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            settled_o   <= 1'b0;
            drop_cnt_o  <= '0;
        end else begin
            blk_valid_o <= adc_valid_i;
            valid_o     <= 1'b0;

            if (stop_i) begin
                state     <= IDLE;
                blk_en_o  <= 1'b0;
                settled_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i && !freeze_i) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                            drop_cnt_o <= '0;
                            settled_o  <= 1'b0;
                            blk_en_o   <= 1'b1;
                        end
                    end

                    SETTLE: begin
                        if (freeze_i) begin
                            state     <= FREEZE;
                            ret_state <= SETTLE;
                            hold_cnt  <= '0;
                            blk_en_o  <= 1'b0;
                        end else if (blk_valid_i) begin
                            // Transient samples are counted and thrown away, including the last one.
                            settle_cnt <= settle_cnt + SW'(1);
                            if (settle_cnt == SETTLE_LAST) begin
                                state     <= RUN;
                                settled_o <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (freeze_i) begin
                            state     <= FREEZE;
                            ret_state <= RUN;
                            hold_cnt  <= '0;
                            blk_en_o  <= 1'b0;
                        end else if (blk_valid_i) begin
                            valid_o <= 1'b1;
                            data_o  <= blk_data_i;
                        end
                    end

                    FREEZE: begin
                        if (adc_valid_i && drop_cnt_o != 16'hFFFF)
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                        // Any freeze request restarts the hold-off; only an unbroken quiet run resumes.
                        if (freeze_i) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= ret_state;
                            blk_en_o <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dc_block_ctrl.sv
// Self-checking bench for dc_block_ctrl: directed vector table, hand sequences for the
// freeze/hold-off/stop corners, and randomized traffic against a cycle-level reference model.
module tb_dc_block_ctrl;

    localparam int DATA_W = 13;
    localparam int SS     = 4;
    localparam int HO     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, stop_i, freeze_i, adc_valid_i, blk_valid_i;
    logic [DATA_W-1:0] blk_data_i;
    logic              blk_en_o, blk_valid_o, valid_o, settled_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        state_o;
    logic [15:0]       drop_cnt_o;

    always #5 clk = ~clk;

    dc_block_ctrl #(.DATA_W(DATA_W), .SETTLE_SAMPLES(SS), .HOLDOFF_CYCLES(HO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .freeze_i(freeze_i),
        .adc_valid_i(adc_valid_i), .blk_en_o(blk_en_o), .blk_valid_o(blk_valid_o),
        .blk_valid_i(blk_valid_i), .blk_data_i(blk_data_i), .valid_o(valid_o),
        .data_o(data_o), .state_o(state_o), .settled_o(settled_o), .drop_cnt_o(drop_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit auto_chk = 1'b1;

    // Reference model: mode names as integers, counters as plain ints.
    localparam int M_IDLE = 0, M_SETTLE = 1, M_RUN = 2, M_FREEZE = 3;
    int          m_state, m_ret, m_settle, m_hold, m_drop;
    bit          m_en, m_bvo, m_valid, m_settled;
    logic [DATA_W-1:0] m_data;

    typedef struct {
        logic              start, freeze, adc, bv;
        logic [DATA_W-1:0] data;
        logic [1:0]        e_state;
        logic              e_en, e_valid, e_settled;
        logic [DATA_W-1:0] e_data;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic s, f, a, b, input logic [DATA_W-1:0] d,
                                input logic [1:0] es, input logic ee, ev, est,
                                input logic [DATA_W-1:0] ed);
        vec_t v;
        v.start = s; v.freeze = f; v.adc = a; v.bv = b; v.data = d;
        v.e_state = es; v.e_en = ee; v.e_valid = ev; v.e_settled = est; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = M_IDLE; m_ret = M_IDLE; m_settle = 0; m_hold = 0; m_drop = 0;
            m_en = 0; m_bvo = 0; m_valid = 0; m_settled = 0; m_data = '0;
            return;
        end
        m_bvo   = adc_valid_i;
        m_valid = 0;
        if (stop_i) begin
            m_state = M_IDLE; m_en = 0; m_settled = 0;
        end else if (m_state == M_IDLE) begin
            if (start_i && !freeze_i) begin
                m_state = M_SETTLE; m_settle = 0; m_drop = 0; m_settled = 0; m_en = 1;
            end
        end else if (m_state == M_FREEZE) begin
            if (adc_valid_i) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            m_hold = freeze_i ? 0 : m_hold + 1;
            if (m_hold == HO) begin
                m_state = m_ret; m_en = 1; m_hold = 0;
            end
        end else if (freeze_i) begin
            m_ret = m_state; m_state = M_FREEZE; m_hold = 0; m_en = 0;
        end else if (blk_valid_i) begin
            if (m_state == M_SETTLE) begin
                m_settle++;
                if (m_settle == SS) begin
                    m_state = M_RUN; m_settled = 1;
                end
            end else begin
                m_valid = 1; m_data = blk_data_i;
            end
        end
    endtask

    task automatic check_all();
        check("state",     32'(state_o),     32'(m_state));
        check("blk_en",    32'(blk_en_o),    32'(m_en));
        check("blk_valid", 32'(blk_valid_o), 32'(m_bvo));
        check("valid",     32'(valid_o),     32'(m_valid));
        check("data",      32'(data_o),      32'(m_data));
        check("settled",   32'(settled_o),   32'(m_settled));
        check("drop_cnt",  32'(drop_cnt_o),  32'(m_drop));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (auto_chk) check_all();
    endtask

    task automatic drive(input logic s, p, f, a, b, input logic [DATA_W-1:0] d);
        start_i = s; stop_i = p; freeze_i = f; adc_valid_i = a; blk_valid_i = b; blk_data_i = d;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, '0);
        rst = 1'b1;

        // Reset: two cycles, everything must be zero.
        auto_chk = 1'b0;
        step(); step();
        auto_chk = 1'b1;
        check("rst_state", 32'(state_o), 0);
        check("rst_outs",  {drop_cnt_o, 3'(data_o), blk_en_o, blk_valid_o, valid_o, settled_o}, 0);
        rst = 1'b0;

        // Idle traffic, arm, settle on four samples, then pass-through with 1-cycle latency.
        vecs[0]  = mk(0, 0, 1, 0, 13'h0000, 2'd0, 0, 0, 0, 13'h0000);
        vecs[1]  = mk(0, 0, 0, 0, 13'h0000, 2'd0, 0, 0, 0, 13'h0000);
        vecs[2]  = mk(1, 0, 0, 0, 13'h0000, 2'd1, 1, 0, 0, 13'h0000);
        vecs[3]  = mk(0, 0, 1, 1, 13'h0005, 2'd1, 1, 0, 0, 13'h0000);
        vecs[4]  = mk(0, 0, 0, 0, 13'h0000, 2'd1, 1, 0, 0, 13'h0000);
        vecs[5]  = mk(0, 0, 0, 1, 13'h0011, 2'd1, 1, 0, 0, 13'h0000);
        vecs[6]  = mk(0, 0, 0, 1, 13'h0022, 2'd1, 1, 0, 0, 13'h0000);
        vecs[7]  = mk(0, 0, 1, 1, 13'h0007, 2'd2, 1, 0, 1, 13'h0000);
        vecs[8]  = mk(0, 0, 0, 1, 13'h0ABC, 2'd2, 1, 1, 1, 13'h0ABC);
        vecs[9]  = mk(0, 0, 1, 0, 13'h0123, 2'd2, 1, 0, 1, 13'h0ABC);
        vecs[10] = mk(0, 0, 0, 1, 13'h1FFD, 2'd2, 1, 1, 1, 13'h1FFD);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].start, 0, vecs[i].freeze, vecs[i].adc, vecs[i].bv, vecs[i].data);
            step();
            check($sformatf("vec%0d_state", i),   32'(state_o),     32'(vecs[i].e_state));
            check($sformatf("vec%0d_en", i),      32'(blk_en_o),    32'(vecs[i].e_en));
            check($sformatf("vec%0d_bvo", i),     32'(blk_valid_o), 32'(vecs[i].adc));
            check($sformatf("vec%0d_valid", i),   32'(valid_o),     32'(vecs[i].e_valid));
            check($sformatf("vec%0d_settled", i), 32'(settled_o),   32'(vecs[i].e_settled));
            check($sformatf("vec%0d_data", i),    32'(data_o),      32'(vecs[i].e_data));
        end

        // Freeze from RUN for 10 cycles spanning two ADC strobes, then a 3-cycle hold-off.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, (i == 2 || i == 6), 0, '0);
            step();
            if (i == 0) check("frz_en_off", 32'(blk_en_o), 0);
        end
        check("frz_state", 32'(state_o), 3);
        check("frz_drop",  32'(drop_cnt_o), 2);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 0, 0, 0, '0);
            step();
            check($sformatf("hold%0d_state", k), 32'(state_o), (k < 3) ? 3 : 2);
            check($sformatf("hold%0d_en", k),    32'(blk_en_o), (k < 3) ? 0 : 1);
        end

        // Glitch at hold-off cycle 2 restarts the count.
        drive(0, 0, 1, 0, 0, '0); step();
        drive(0, 0, 0, 0, 0, '0); step(); step();
        drive(0, 0, 1, 0, 0, '0); step();
        check("glitch_state", 32'(state_o), 3);
        drive(0, 0, 0, 0, 0, '0); step(); step();
        check("glitch_hold2", 32'(state_o), 3);
        step();
        check("glitch_resume", 32'(state_o), 2);

        // Freeze after two settle samples; freeze also beats a final settle sample.
        drive(0, 1, 0, 0, 0, '0); step();
        drive(1, 0, 0, 0, 0, '0); step();
        check("rearm_drop", 32'(drop_cnt_o), 0);
        drive(0, 0, 0, 0, 1, '0); step(); step();
        drive(0, 0, 1, 0, 0, '0); step();
        drive(0, 0, 0, 0, 0, '0); step(); step(); step();
        check("resume_settle", 32'(state_o), 1);
        drive(0, 0, 0, 0, 1, '0); step();
        check("settle3", 32'(state_o), 1);
        drive(0, 0, 1, 0, 1, '0); step();
        check("frz_wins", 32'(state_o), 3);
        drive(0, 0, 0, 0, 0, '0); step(); step(); step();
        check("resume2_settle", 32'(state_o), 1);
        check("resume2_notset", 32'(settled_o), 0);
        drive(0, 0, 0, 0, 1, 13'h0F0F); step();
        check("settle4_run", 32'(state_o), 2);
        check("settle4_set",  32'(settled_o), 1);
        check("settle4_nov",  32'(valid_o), 0);

        // Stop during FREEZE with freeze held; drop count survives until the next start.
        drive(0, 0, 1, 1, 0, '0); step(); step(); step();
        check("pre_stop_drop", 32'(drop_cnt_o), 2);
        drive(0, 1, 1, 1, 0, '0); step();
        check("stop_state",   32'(state_o), 0);
        check("stop_en",      32'(blk_en_o), 0);
        check("stop_settled", 32'(settled_o), 0);
        check("stop_drop",    32'(drop_cnt_o), 2);
        drive(1, 1, 0, 0, 0, '0); step();
        check("start_stop_idle", 32'(state_o), 0);
        drive(1, 0, 0, 0, 0, '0); step();
        check("start_clr_drop", 32'(drop_cnt_o), 0);
        check("start_state",    32'(state_o), 1);

        // Saturation of the drop counter.
        drive(0, 0, 1, 1, 0, '0);
        auto_chk = 1'b0;
        for (int i = 0; i < 70000; i++) step();
        auto_chk = 1'b1;
        check("drop_sat", 32'(drop_cnt_o), 32'h0000FFFF);
        step();
        check("drop_sat_hold", 32'(drop_cnt_o), 32'h0000FFFF);

        // Randomized traffic against the model.
        drive(0, 1, 0, 0, 0, '0); step();
        for (int i = 0; i < 4000; i++) begin
            logic f;
            f = ($urandom_range(9) < 2);
            drive(!f && ($urandom_range(15) == 0), ($urandom_range(63) == 0), f,
                  ($urandom_range(3) == 0), ($urandom_range(2) == 0), DATA_W'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
